aes_128_key_writer: RTL and testbench

- Key-load master for the AES-128 round-key RAM.
- Takes a 128-bit cipher key and expands it on the fly into the 11 AES-128 round keys (FIPS-197).
- Streams the round keys into the key RAM write port as 22 × 64-bit words on the en_wr / addr_wr / key_round_wr bus that aes_128_top exposes.
- Sits beside aes_128_top and replaces host-side key expansion.

---
 rtl/aes_128_pkg.sv | 38 +++
 rtl/aes_128_key_writer_if.sv | 11 +
 rtl/aes_128_key_step.sv | 29 ++
 rtl/aes_128_key_writer.sv | 122 ++++++++++++
 tb/tb_aes_128_key_writer.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/aes_128_pkg.sv
// Shared AES-128 constants: S-box table, xtime, rcon seed and key-writer state encoding.
package aes_128_pkg;

  localparam int unsigned ROUND_KEYS    = 11;
  localparam int unsigned WORDS_PER_KEY = 2;
  localparam logic [7:0]  RCON_INIT     = 8'h01;

  typedef enum logic [1:0] {IDLE, WR_HI, WR_LO, DONE} kw_state_e;

  // Row-major FIPS-197 S-box; element 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_128_key_writer_if.sv
// Key RAM write bus between the key writer (master) and the round-key RAM (slave).
interface aes_128_key_writer_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              en_wr;
  logic [ADDR_W-1:0] addr_wr;
  logic [63:0]       key_round_wr;

  modport master (output en_wr, addr_wr, key_round_wr);
  modport slave  (input  en_wr, addr_wr, key_round_wr);
endinterface

// File: rtl/aes_128_key_step.sv
// One AES-128 key-schedule step: rk -> next round key using rcon, four S-box lookups.
module aes_128_key_step
  import aes_128_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);

  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] t;
  logic [31:0] w0n, w1n, w2n, w3n;

  always_comb begin
    rot = {rk[23:0], rk[31:24]};
    sub = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sub[i*8 +: 8] = sbox(rot[i*8 +: 8]);
    end
    t       = sub ^ {rcon, 24'h0};
    w0n     = rk[127:96] ^ t;
    w1n     = rk[95:64]  ^ w0n;
    w2n     = rk[63:32]  ^ w1n;
    w3n     = rk[31:0]   ^ w2n;
    rk_next = {w0n, w1n, w2n, w3n};
  end

endmodule

// File: rtl/aes_128_key_writer.sv
// Expands a 128-bit key into 11 round keys and streams them as 22 x 64-bit RAM writes.
// Define AES_KEY_WR_REVERSE_EN to store round 10 at address 0 (decrypt ordering).
module aes_128_key_writer
  import aes_128_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                clk,
  input  logic                kill_n,
  input  logic [127:0]        key_in,
  input  logic                key_start,
  output logic                busy,
  output logic                done,
  aes_128_key_writer_if.master ram
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  kw_state_e         state, state_nxt;
  logic [127:0]      rk, rk_nxt, step_out;
  logic [3:0]        r, r_nxt;
  logic [7:0]        rcon, rcon_nxt;
  logic              busy_nxt, done_nxt, en_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [63:0]       data_nxt;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [3:0] rnd, input logic lo);
    logic [3:0] slot;
`ifdef AES_KEY_WR_REVERSE_EN
    slot = LAST_ROUND - rnd;
`else
    slot = rnd;
`endif
    return ADDR_W'({slot, lo});
  endfunction

  aes_128_key_step u_step (
    .rk      (rk),
    .rcon    (rcon),
    .rk_next (step_out)
  );

  // Outputs are computed for the next state and registered, so the bus
  // presents each word during the cycle its state is occupied.
  always_comb begin
    state_nxt = state;
    rk_nxt    = rk;
    r_nxt     = r;
    rcon_nxt  = rcon;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    en_nxt    = 1'b0;
    addr_nxt  = ram.addr_wr;
    data_nxt  = ram.key_round_wr;
    unique case (state)
      IDLE: begin
        if (key_start) begin
          rk_nxt    = key_in;
          r_nxt     = '0;
          rcon_nxt  = RCON_INIT;
          state_nxt = WR_HI;
          busy_nxt  = 1'b1;
          en_nxt    = 1'b1;
          addr_nxt  = word_addr(4'd0, 1'b0);
          data_nxt  = key_in[127:64];
        end
      end
      WR_HI: begin
        state_nxt = WR_LO;
        busy_nxt  = 1'b1;
        en_nxt    = 1'b1;
        addr_nxt  = word_addr(r, 1'b1);
        data_nxt  = rk[63:0];
      end
      WR_LO: begin
        rk_nxt   = step_out;
        rcon_nxt = xtime(rcon);
        if (r == LAST_ROUND) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          r_nxt     = r + 4'd1;
          state_nxt = WR_HI;
          busy_nxt  = 1'b1;
          en_nxt    = 1'b1;
          addr_nxt  = word_addr(r + 4'd1, 1'b0);
          data_nxt  = step_out[127:64];
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state            <= IDLE;
      rk               <= '0;
      r                <= '0;
      rcon             <= RCON_INIT;
      busy             <= 1'b0;
      done             <= 1'b0;
      ram.en_wr        <= 1'b0;
      ram.addr_wr      <= '0;
      ram.key_round_wr <= '0;
    end else begin
      state            <= state_nxt;
      rk               <= rk_nxt;
      r                <= r_nxt;
      rcon             <= rcon_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
      ram.en_wr        <= en_nxt;
      ram.addr_wr      <= addr_nxt;
      ram.key_round_wr <= data_nxt;
    end
  end

endmodule

// File: tb/tb_aes_128_key_writer.sv
// Directed bench for aes_128_key_writer: FIPS-197 and all-zero keys, start filtering, mid-load reset.
module tb_aes_128_key_writer;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  logic         clk = 1'b0;
  logic         kill_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_start = 1'b0;
  logic         busy, done;

  aes_128_key_writer_if #(.ADDR_W(5)) ram ();

  aes_128_key_writer #(.NUM_ROUNDS(10), .ADDR_W(5)) dut (
    .clk       (clk),
    .kill_n    (kill_n),
    .key_in    (key_in),
    .key_start (key_start),
    .busy      (busy),
    .done      (done),
    .ram       (ram)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    int           rnd;
    bit           lo;
    logic [63:0]  data;
  } vec_t;

  vec_t        vecs [16];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mem [22];
  int          wr_cnt, first_wr, last_wr, done_cnt, done_cyc, busy_bad, addr_bad;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_addr(input int rnd, input bit lo);
`ifdef AES_KEY_WR_REVERSE_EN
    return 2 * (10 - rnd) + int'(lo);
`else
    return 2 * rnd + int'(lo);
`endif
  endfunction

  // Starts a load at the current negedge, then observes cycles 1..win.
  task automatic run_load(input logic [127:0] key, input int p1, input int p2,
                          input int kill_cyc, input int win);
    key_in    = key;
    key_start = 1'b1;
    wr_cnt = 0; first_wr = 0; last_wr = 0; done_cnt = 0; done_cyc = 0;
    busy_bad = 0; addr_bad = 0;
    for (int i = 0; i < 22; i++) mem[i] = 'x;
    for (int cyc = 1; cyc <= win; cyc++) begin
      @(negedge clk);
      if (ram.en_wr === 1'b1) begin
        if (wr_cnt == 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
        if (ram.addr_wr < 5'd22) mem[ram.addr_wr] = ram.key_round_wr;
        else addr_bad++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy !== ram.en_wr) busy_bad++;
      key_start = (cyc == p1) || (cyc == p2);
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      if (cyc == kill_cyc) begin
        key_start = 1'b0;
        kill_n    = 1'b0;
        #1;
        chk("kill_en_wr", ram.en_wr, 0);
        chk("kill_busy", busy, 0);
        chk("kill_done", done, 0);
      end
      if (kill_cyc != 0 && cyc == kill_cyc + 2) kill_n = 1'b1;
    end
  endtask

  task automatic check_timing(input string tag);
    chk({tag, "_writes"}, wr_cnt, 22);
    chk({tag, "_first_wr_cycle"}, first_wr, 1);
    chk({tag, "_last_wr_cycle"}, last_wr, 22);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_cyc, 23);
    chk({tag, "_busy_vs_en_wr"}, busy_bad, 0);
    chk({tag, "_addr_range"}, addr_bad, 0);
  endtask

  task automatic check_table(input string tag, input logic [127:0] key);
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].key == key)
        chk($sformatf("%s_rk%0d_%s", tag, vecs[i].rnd, vecs[i].lo ? "lo" : "hi"),
            mem[exp_addr(vecs[i].rnd, vecs[i].lo)], vecs[i].data);
    end
  endtask

  initial begin
    vecs[0]  = '{KEY_FIPS, 0,  1'b0, 64'h2b7e151628aed2a6};
    vecs[1]  = '{KEY_FIPS, 0,  1'b1, 64'habf7158809cf4f3c};
    vecs[2]  = '{KEY_FIPS, 1,  1'b0, 64'ha0fafe1788542cb1};
    vecs[3]  = '{KEY_FIPS, 1,  1'b1, 64'h23a339392a6c7605};
    vecs[4]  = '{KEY_FIPS, 2,  1'b0, 64'hf2c295f27a96b943};
    vecs[5]  = '{KEY_FIPS, 2,  1'b1, 64'h5935807a7359f67f};
    vecs[6]  = '{KEY_FIPS, 10, 1'b0, 64'hd014f9a8c9ee2589};
    vecs[7]  = '{KEY_FIPS, 10, 1'b1, 64'he13f0cc8b6630ca6};
    vecs[8]  = '{KEY_ZERO, 0,  1'b0, 64'h0000000000000000};
    vecs[9]  = '{KEY_ZERO, 0,  1'b1, 64'h0000000000000000};
    vecs[10] = '{KEY_ZERO, 1,  1'b0, 64'h6263636362636363};
    vecs[11] = '{KEY_ZERO, 1,  1'b1, 64'h6263636362636363};
    vecs[12] = '{KEY_ZERO, 2,  1'b0, 64'h9b9898c9f9fbfbaa};
    vecs[13] = '{KEY_ZERO, 2,  1'b1, 64'h9b9898c9f9fbfbaa};
    vecs[14] = '{KEY_ZERO, 10, 1'b0, 64'hb4ef5bcb3e92e211};
    vecs[15] = '{KEY_ZERO, 10, 1'b1, 64'h23e951cf6f8f188e};

    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_en_wr", ram.en_wr, 0);
    chk("reset_addr_wr", ram.addr_wr, 0);
    chk("reset_data", ram.key_round_wr, 0);
    @(negedge clk);
    kill_n = 1'b1;
    @(negedge clk);

    run_load(KEY_FIPS, 0, 0, 0, 24);
    check_timing("fips");
    check_table("fips", KEY_FIPS);
    chk("hold_addr", ram.addr_wr, exp_addr(10, 1'b1));
    chk("hold_data", ram.key_round_wr, 64'he13f0cc8b6630ca6);

    // Extra starts at cycles 5 and 23 must be ignored; the next call's start lands on cycle 24.
    run_load(KEY_ZERO, 5, 23, 0, 24);
    check_timing("ignore_starts");
    check_table("zero", KEY_ZERO);

    run_load(KEY_FIPS, 0, 0, 0, 24);
    check_timing("restart_c24");
    check_table("restart", KEY_FIPS);

    run_load(KEY_ZERO, 0, 0, 10, 24);
    chk("kill_writes", wr_cnt, 10);
    chk("kill_done_pulses", done_cnt, 0);

    run_load(KEY_FIPS, 0, 0, 0, 24);
    check_timing("reload");
    check_table("reload", KEY_FIPS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
